dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: the core (DAG/sequencer path) and a DMA engine.
- Sits between the requesters and the DM block. Drives ps_dm_cslt, ps_dm_wrb, dg_dm_add and bc_dt, and returns dm_bc_dt to the requester that owns the read.
- The core has fixed priority. A starvation counter guarantees DMA a slot after STARVE_MAX consecutive lost contentions.
- Write data is re-timed to meet the DM's execute+1 write timing.

Parameters:
DMA_SIZE, 17, DM address width
DMD_SIZE, 16, DM data width
STARVE_MAX, 4, max consecutive contended cycles DMA may lose (legal range 1..255)
STAT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
core_req  in  1  core requests DM access this cycle
core_wrb  in  1  1=write, 0=read
core_add  in  DMA_SIZE  core address
core_wdt  in  DMD_SIZE  core write data (valid with core_req & core_wrb)
core_gnt  out  1  core access accepted this cycle (combinational)
core_rvld  out  1  read data for core on rd_dt (registered)
dma_req  in  1  DMA requests DM access
dma_wrb  in  1  1=write, 0=read
dma_add  in  DMA_SIZE  DMA address
dma_wdt  in  DMD_SIZE  DMA write data
dma_gnt  out  1  DMA access accepted this cycle (combinational)
dma_rvld  out  1  read data for DMA on rd_dt (registered)
rd_dt  out  DMD_SIZE  read return, equals dm_bc_dt
ps_dm_cslt  out  1  DM chip select
ps_dm_wrb  out  1  DM write strobe
dg_dm_add  out  DMA_SIZE  DM address
bc_dt  out  DMD_SIZE  DM write data (registered)
dm_bc_dt  in  DMD_SIZE  DM read data
core_grant_cnt  out  STAT_W  core grants (optional feature)
dma_grant_cnt  out  STAT_W  DMA grants (optional feature)
core_stall_cnt  out  STAT_W  cycles core_req held without grant (optional feature)

Behaviour:
- Reset (async, rst_n=0): core_rvld=0, dma_rvld=0, bc_dt=0, starvation counter=0, stats=0, state=CORE_PRI. Combinational outputs follow their equations.
- States:
  - CORE_PRI (default).
  - DMA_FORCE: entered when the starvation counter reaches STARVE_MAX with dma_req high.
- Arbitration in CORE_PRI:
  - core_req alone → core_gnt=1.
  - dma_req alone → dma_gnt=1; counter←0.
  - Both requesting → core_gnt=1; counter←counter+1. If counter+1==STARVE_MAX, next state←DMA_FORCE.
  - No dma_req → counter←0.
- Arbitration in DMA_FORCE:
  - dma_req → dma_gnt=1, core_gnt=0 even if core_req; counter←0; next state←CORE_PRI.
  - DMA dropped its request → no grant to DMA; core served as in CORE_PRI; counter←0; next state←CORE_PRI.
- Grants are mutually exclusive; never both 1.
- Memory-side outputs:
  - ps_dm_cslt = core_gnt | dma_gnt.
  - ps_dm_wrb and dg_dm_add are muxed from the winner. When idle: wrb=0, address=0.
- Write timing: DM latches address/wrb at the grant edge and writes bc_dt one cycle later. Therefore bc_dt ← winner's wdata on every write grant, and holds its value otherwise.
  - Back-to-back writes: the bc_dt pipeline carries each word exactly one cycle behind its address.
  - A read granted the cycle after a write to the same address returns the new data via the DM bypass. No arbiter hazard logic is needed.
- Read latency: grant in cycle N → {core|dma}_rvld=1 in cycle N+1 with rd_dt=dm_bc_dt. The rvld registers are set from the read-grant owner and cleared otherwise.
- Requester rule: a requester holds req/wrb/add/wdt stable until it sees its gnt. A request may be withdrawn before grant without side effects.
- Reset mid-operation: an outstanding rvld is cleared and the read is lost. A write granted in the cycle before reset may be committed by the DM with bc_dt=0. Requesters re-issue after reset.

Optional Feature:
- Macro: DM_PORT_ARB_STATS_EN.
- Defined:
  - core_grant_cnt and dma_grant_cnt increment on each grant.
  - core_stall_cnt increments on each cycle with core_req & ~core_gnt.
  - All three saturate at all-ones and clear on reset.
- Undefined: the three ports remain and are tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package dm_arb_pkg:
  - state enum {CORE_PRI, DMA_FORCE};
  - requester id encoding (ID_CORE=0, ID_DMA=1);
  - default widths DMA_SIZE=17, DMD_SIZE=16.
- One natural sub-module: dm_arb_sat_counter (parameterised STAT_W saturating counter with enable), instantiated three times under the macro.

Test Plan:
- Core-only read: core_req=1, add=0x0000A for 1 cycle → core_gnt=1, ps_dm_cslt=1, dg_dm_add=0x0000A; next cycle core_rvld=1 with rd_dt = DM content.
- DMA write then core read, same address: DMA write 0x00010/0xFFEE in cycle N; core read 0x00010 in N+1 → bc_dt=0xFFEE in N+1; core_rvld=1 in N+2 with rd_dt=0xFFEE.
- Starvation with STARVE_MAX=4: both requesting continuously → core granted 4 cycles, DMA granted on the 5th, core_gnt=0 that cycle; pattern repeats with period 5.
- DMA drops its request while in DMA_FORCE → core granted that cycle; counter=0; state returns to CORE_PRI.
- Back-to-back core writes 0x1/0xAAAA, 0x2/0x5555 → bc_dt=0xAAAA in cycle N+1 and 0x5555 in N+2; a subsequent DM readback returns both values.
- Async reset asserted mid-read (rst_n low between clock edges) → core_rvld/dma_rvld/bc_dt go 0 immediately; with DM_PORT_ARB_STATS_EN, the counters read 0 after reset; after 3 contended cycles, core_stall_cnt=0 and core_grant_cnt=3.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dm_arb_pkg;

    localparam int DMA_SIZE_DEF = 17;
    localparam int DMD_SIZE_DEF = 16;

    typedef enum logic {
        CORE_PRI  = 1'b0,
        DMA_FORCE = 1'b1
    } arb_state_t;

    typedef enum logic {
        ID_CORE = 1'b0,
        ID_DMA  = 1'b1
    } req_id_t;

    // Arbiter state register; kept as one struct so state and starvation count are visible together.
    typedef struct packed {
        arb_state_t state;
        logic [7:0] starve_cnt;
    } arb_dbg_t;

endpackage

// File: rtl/dm_arb_sat_counter.sv
// Saturating up-counter with enable, used for the optional arbiter statistics.
module dm_arb_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single DM port between the core (fixed priority) and a DMA engine with starvation relief.
// Statistics counters are built only when DM_PORT_ARB_STATS_EN is defined.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DMA_SIZE   = DMA_SIZE_DEF,
    parameter int DMD_SIZE   = DMD_SIZE_DEF,
    parameter int STARVE_MAX = 4,
    parameter int STAT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                core_req,
    input  logic                core_wrb,
    input  logic [DMA_SIZE-1:0] core_add,
    input  logic [DMD_SIZE-1:0] core_wdt,
    output logic                core_gnt,
    output logic                core_rvld,
    input  logic                dma_req,
    input  logic                dma_wrb,
    input  logic [DMA_SIZE-1:0] dma_add,
    input  logic [DMD_SIZE-1:0] dma_wdt,
    output logic                dma_gnt,
    output logic                dma_rvld,
    output logic [DMD_SIZE-1:0] rd_dt,
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt,
    output logic [STAT_W-1:0]   core_grant_cnt,
    output logic [STAT_W-1:0]   dma_grant_cnt,
    output logic [STAT_W-1:0]   core_stall_cnt
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    // Handshake: a requester holds req/wrb/add/wdt stable until its gnt is seen high in the
    // same cycle; req with gnt is the transfer. Dropping req before gnt cancels with no side effects.

    arb_dbg_t            arb_q;
    req_id_t             win_id;
    logic                force_dma;
    logic                starve_inc;
    logic [7:0]          cnt_next;
    logic [DMD_SIZE-1:0] wr_dt;

    always_comb begin
        force_dma  = (arb_q.state == DMA_FORCE) && dma_req;
        core_gnt   = core_req && !force_dma;
        dma_gnt    = dma_req && (!core_req || force_dma);
        win_id     = dma_gnt ? ID_DMA : ID_CORE;
        ps_dm_cslt = core_gnt || dma_gnt;
        ps_dm_wrb  = 1'b0;
        dg_dm_add  = '0;
        wr_dt      = core_wdt;
        if (ps_dm_cslt) begin
            if (win_id == ID_DMA) begin
                ps_dm_wrb = dma_wrb;
                dg_dm_add = dma_add;
                wr_dt     = dma_wdt;
            end else begin
                ps_dm_wrb = core_wrb;
                dg_dm_add = core_add;
            end
        end
        starve_inc = (arb_q.state == CORE_PRI) && core_req && dma_req;
        cnt_next   = arb_q.starve_cnt + 8'd1;
    end

    assign rd_dt = dm_bc_dt;

    // bc_dt trails the granted address by one cycle, matching the DM's execute+1 write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_q     <= '{state: CORE_PRI, starve_cnt: 8'd0};
            core_rvld <= 1'b0;
            dma_rvld  <= 1'b0;
            bc_dt     <= '0;
        end else begin
            core_rvld <= core_gnt && !core_wrb;
            dma_rvld  <= dma_gnt && !dma_wrb;
            if (ps_dm_cslt && ps_dm_wrb) begin
                bc_dt <= wr_dt;
            end
            if (starve_inc) begin
                arb_q.starve_cnt <= cnt_next;
                arb_q.state      <= (cnt_next == STARVE_LIM) ? DMA_FORCE : CORE_PRI;
            end else begin
                arb_q.starve_cnt <= 8'd0;
                arb_q.state      <= CORE_PRI;
            end
        end
    end

`ifdef DM_PORT_ARB_STATS_EN
    dm_arb_sat_counter #(.W(STAT_W)) u_core_grant_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (core_gnt),
        .cnt   (core_grant_cnt)
    );

    dm_arb_sat_counter #(.W(STAT_W)) u_dma_grant_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dma_gnt),
        .cnt   (dma_grant_cnt)
    );

    dm_arb_sat_counter #(.W(STAT_W)) u_core_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (core_req && !core_gnt),
        .cnt   (core_stall_cnt)
    );
`else
    assign core_grant_cnt = '0;
    assign dma_grant_cnt  = '0;
    assign core_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small behavioural DM (execute+1 write, registered address).
module tb_dm_port_arbiter;

    localparam int DMA_SIZE = 17;
    localparam int DMD_SIZE = 16;
    localparam int STAT_W   = 16;
`ifdef DM_PORT_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                core_req = 1'b0, core_wrb = 1'b0;
    logic [DMA_SIZE-1:0] core_add = '0;
    logic [DMD_SIZE-1:0] core_wdt = '0;
    logic                dma_req = 1'b0, dma_wrb = 1'b0;
    logic [DMA_SIZE-1:0] dma_add = '0;
    logic [DMD_SIZE-1:0] dma_wdt = '0;
    logic                core_gnt, core_rvld, dma_gnt, dma_rvld;
    logic [DMD_SIZE-1:0] rd_dt, bc_dt, dm_bc_dt;
    logic                ps_dm_cslt, ps_dm_wrb;
    logic [DMA_SIZE-1:0] dg_dm_add;
    logic [STAT_W-1:0]   core_grant_cnt, dma_grant_cnt, core_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dm_port_arbiter #(
        .DMA_SIZE(DMA_SIZE), .DMD_SIZE(DMD_SIZE), .STARVE_MAX(4), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_wrb(core_wrb), .core_add(core_add), .core_wdt(core_wdt),
        .core_gnt(core_gnt), .core_rvld(core_rvld),
        .dma_req(dma_req), .dma_wrb(dma_wrb), .dma_add(dma_add), .dma_wdt(dma_wdt),
        .dma_gnt(dma_gnt), .dma_rvld(dma_rvld),
        .rd_dt(rd_dt), .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb),
        .dg_dm_add(dg_dm_add), .bc_dt(bc_dt), .dm_bc_dt(dm_bc_dt),
        .core_grant_cnt(core_grant_cnt), .dma_grant_cnt(dma_grant_cnt),
        .core_stall_cnt(core_stall_cnt)
    );

    // DM model: address/wrb latched at the grant edge, write data taken from bc_dt one edge later.
    bit [DMD_SIZE-1:0] mem [0:255];
    bit [7:0]          lat_addr;
    bit [7:0]          wr_addr;
    bit                wr_pend;
    bit                mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= DMD_SIZE'(i * 3);
            mem[8'h0A] <= 16'h1234;
            mem_init   <= 1'b1;
        end else if (wr_pend) begin
            mem[wr_addr] <= bc_dt;
        end
        wr_pend  <= ps_dm_cslt && ps_dm_wrb;
        wr_addr  <= dg_dm_add[7:0];
        lat_addr <= dg_dm_add[7:0];
    end

    assign dm_bc_dt = mem[lat_addr];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (core_rvld !== 1'b0) begin n_errors++; $display("FAIL reset_core_rvld: got %b want 0", core_rvld); end
        n_checks++; if (dma_rvld !== 1'b0) begin n_errors++; $display("FAIL reset_dma_rvld: got %b want 0", dma_rvld); end
        n_checks++; if (bc_dt !== 16'h0000) begin n_errors++; $display("FAIL reset_bc_dt: got %h want 0000", bc_dt); end
        n_checks++; if (ps_dm_cslt !== 1'b0 || dg_dm_add !== 17'h0) begin n_errors++; $display("FAIL reset_idle_port: cslt %b add %h want 0/0", ps_dm_cslt, dg_dm_add); end
        n_checks++; if (core_grant_cnt !== 16'h0 || dma_grant_cnt !== 16'h0 || core_stall_cnt !== 16'h0) begin
            n_errors++; $display("FAIL reset_stats: got %h/%h/%h want 0/0/0", core_grant_cnt, dma_grant_cnt, core_stall_cnt);
        end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_core_read();
        core_req = 1'b1; core_wrb = 1'b0; core_add = 17'h0000A;
        @(negedge clk);
        n_checks++; if (core_gnt !== 1'b1 || dma_gnt !== 1'b0) begin n_errors++; $display("FAIL core_read_gnt: core %b dma %b want 1/0", core_gnt, dma_gnt); end
        n_checks++; if (ps_dm_cslt !== 1'b1 || ps_dm_wrb !== 1'b0 || dg_dm_add !== 17'h0000A) begin
            n_errors++; $display("FAIL core_read_port: cslt %b wrb %b add %h want 1/0/0000a", ps_dm_cslt, ps_dm_wrb, dg_dm_add);
        end
        next_cycle();
        core_req = 1'b0;
        @(negedge clk);
        n_checks++; if (core_rvld !== 1'b1 || dma_rvld !== 1'b0) begin n_errors++; $display("FAIL core_read_rvld: core %b dma %b want 1/0", core_rvld, dma_rvld); end
        n_checks++; if (rd_dt !== 16'h1234) begin n_errors++; $display("FAIL core_read_data: got %h want 1234", rd_dt); end
        n_checks++; if (ps_dm_cslt !== 1'b0 || dg_dm_add !== 17'h0) begin n_errors++; $display("FAIL core_read_idle: cslt %b add %h want 0/0", ps_dm_cslt, dg_dm_add); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (core_rvld !== 1'b0) begin n_errors++; $display("FAIL core_read_rvld_clear: got %b want 0", core_rvld); end
        next_cycle();
    endtask

    task automatic test_dma_write_core_read();
        dma_req = 1'b1; dma_wrb = 1'b1; dma_add = 17'h00010; dma_wdt = 16'hFFEE;
        @(negedge clk);
        n_checks++; if (dma_gnt !== 1'b1 || core_gnt !== 1'b0) begin n_errors++; $display("FAIL dma_wr_gnt: dma %b core %b want 1/0", dma_gnt, core_gnt); end
        n_checks++; if (ps_dm_wrb !== 1'b1 || dg_dm_add !== 17'h00010) begin n_errors++; $display("FAIL dma_wr_port: wrb %b add %h want 1/00010", ps_dm_wrb, dg_dm_add); end
        next_cycle();
        dma_req = 1'b0; dma_wrb = 1'b0;
        core_req = 1'b1; core_wrb = 1'b0; core_add = 17'h00010;
        @(negedge clk);
        n_checks++; if (bc_dt !== 16'hFFEE) begin n_errors++; $display("FAIL dma_wr_bc_dt: got %h want ffee", bc_dt); end
        n_checks++; if (core_gnt !== 1'b1 || ps_dm_wrb !== 1'b0) begin n_errors++; $display("FAIL bypass_read_gnt: gnt %b wrb %b want 1/0", core_gnt, ps_dm_wrb); end
        next_cycle();
        core_req = 1'b0;
        @(negedge clk);
        n_checks++; if (core_rvld !== 1'b1 || dma_rvld !== 1'b0) begin n_errors++; $display("FAIL bypass_read_rvld: core %b dma %b want 1/0", core_rvld, dma_rvld); end
        n_checks++; if (rd_dt !== 16'hFFEE) begin n_errors++; $display("FAIL bypass_read_data: got %h want ffee", rd_dt); end
        next_cycle();
    endtask

    task automatic test_starvation();
        bit exp_dma;
        bit prev_dma = 1'b0;
        core_req = 1'b1; core_wrb = 1'b0; core_add = 17'h00020;
        dma_req  = 1'b1; dma_wrb  = 1'b0; dma_add  = 17'h00030;
        for (int i = 0; i < 10; i++) begin
            exp_dma = ((i % 5) == 4);
            @(negedge clk);
            n_checks++; if (core_gnt !== !exp_dma || dma_gnt !== exp_dma) begin
                n_errors++; $display("FAIL starve_gnt[%0d]: core %b dma %b want %b/%b", i, core_gnt, dma_gnt, !exp_dma, exp_dma);
            end
            n_checks++; if (dg_dm_add !== (exp_dma ? 17'h00030 : 17'h00020)) begin
                n_errors++; $display("FAIL starve_add[%0d]: got %h want %h", i, dg_dm_add, exp_dma ? 17'h00030 : 17'h00020);
            end
            if (i > 0) begin
                n_checks++; if (dma_rvld !== prev_dma || core_rvld !== !prev_dma) begin
                    n_errors++; $display("FAIL starve_rvld[%0d]: core %b dma %b want %b/%b", i, core_rvld, dma_rvld, !prev_dma, prev_dma);
                end
            end
            prev_dma = exp_dma;
            next_cycle();
        end
        core_req = 1'b0; dma_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_force_drop();
        core_req = 1'b1; core_wrb = 1'b0; core_add = 17'h00040;
        dma_req  = 1'b1; dma_wrb  = 1'b0; dma_add  = 17'h00050;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (core_gnt !== 1'b1 || dma_gnt !== 1'b0) begin n_errors++; $display("FAIL drop_pre[%0d]: core %b dma %b want 1/0", i, core_gnt, dma_gnt); end
            next_cycle();
        end
        dma_req = 1'b0;
        @(negedge clk);
        n_checks++; if (core_gnt !== 1'b1 || dma_gnt !== 1'b0) begin n_errors++; $display("FAIL drop_core_served: core %b dma %b want 1/0", core_gnt, dma_gnt); end
        next_cycle();
        dma_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (core_gnt !== (i != 4) || dma_gnt !== (i == 4)) begin
                n_errors++; $display("FAIL drop_restart[%0d]: core %b dma %b want %b/%b", i, core_gnt, dma_gnt, i != 4, i == 4);
            end
            next_cycle();
        end
        core_req = 1'b0; dma_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        core_req = 1'b1; core_wrb = 1'b1; core_add = 17'h00001; core_wdt = 16'hAAAA;
        next_cycle();
        core_add = 17'h00002; core_wdt = 16'h5555;
        @(negedge clk);
        n_checks++; if (bc_dt !== 16'hAAAA) begin n_errors++; $display("FAIL b2b_bc_dt_first: got %h want aaaa", bc_dt); end
        next_cycle();
        core_req = 1'b0; core_wrb = 1'b0; core_wdt = 16'h0000;
        @(negedge clk);
        n_checks++; if (bc_dt !== 16'h5555) begin n_errors++; $display("FAIL b2b_bc_dt_second: got %h want 5555", bc_dt); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (bc_dt !== 16'h5555) begin n_errors++; $display("FAIL b2b_bc_dt_hold: got %h want 5555", bc_dt); end
        core_req = 1'b1; core_add = 17'h00001;
        next_cycle();
        core_add = 17'h00002;
        @(negedge clk);
        n_checks++; if (core_rvld !== 1'b1 || rd_dt !== 16'hAAAA) begin n_errors++; $display("FAIL b2b_readback_1: rvld %b data %h want 1/aaaa", core_rvld, rd_dt); end
        next_cycle();
        core_req = 1'b0;
        @(negedge clk);
        n_checks++; if (core_rvld !== 1'b1 || rd_dt !== 16'h5555) begin n_errors++; $display("FAIL b2b_readback_2: rvld %b data %h want 1/5555", core_rvld, rd_dt); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        core_req = 1'b1; core_wrb = 1'b0; core_add = 17'h0000A;
        next_cycle();
        core_req = 1'b0;
        n_checks++; if (core_rvld !== 1'b1 || bc_dt !== 16'h5555) begin n_errors++; $display("FAIL midrst_pre: rvld %b bc_dt %h want 1/5555", core_rvld, bc_dt); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (core_rvld !== 1'b0 || dma_rvld !== 1'b0) begin n_errors++; $display("FAIL midrst_rvld: core %b dma %b want 0/0", core_rvld, dma_rvld); end
        n_checks++; if (bc_dt !== 16'h0000) begin n_errors++; $display("FAIL midrst_bc_dt: got %h want 0000", bc_dt); end
        @(negedge clk);
        n_checks++; if (core_grant_cnt !== 16'h0 || dma_grant_cnt !== 16'h0 || core_stall_cnt !== 16'h0) begin
            n_errors++; $display("FAIL midrst_stats: got %h/%h/%h want 0/0/0", core_grant_cnt, dma_grant_cnt, core_stall_cnt);
        end
        rst_n = 1'b1;
        next_cycle();
        core_req = 1'b1; core_add = 17'h00060;
        dma_req  = 1'b1; dma_wrb = 1'b0; dma_add = 17'h00070;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (core_grant_cnt !== (STATS_ON ? 16'd3 : 16'd0) || core_stall_cnt !== 16'd0 || dma_grant_cnt !== 16'd0) begin
            n_errors++; $display("FAIL stats_3_contended: core %0d stall %0d dma %0d want %0d/0/0", core_grant_cnt, core_stall_cnt, dma_grant_cnt, STATS_ON ? 3 : 0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (core_grant_cnt !== (STATS_ON ? 16'd4 : 16'd0) || core_stall_cnt !== (STATS_ON ? 16'd1 : 16'd0)
                        || dma_grant_cnt !== (STATS_ON ? 16'd1 : 16'd0)) begin
            n_errors++; $display("FAIL stats_forced_slot: core %0d stall %0d dma %0d want %0d/%0d/%0d", core_grant_cnt, core_stall_cnt, dma_grant_cnt,
                                 STATS_ON ? 4 : 0, STATS_ON ? 1 : 0, STATS_ON ? 1 : 0);
        end
        core_req = 1'b0; dma_req = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_dma_write_core_read();
        test_starvation();
        test_force_drop();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
